fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the instruction cache.
- Owns the program counter and drives the fetch address to the cache.
- Absorbs cache miss stalls (busywait) and pipeline stalls from hazard logic.
- Handles branch/jump redirects, including redirects that arrive mid-miss, and loads the IF/ID pipeline register.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit_if_id_reg.sv | 45 ++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// default parameters and small helpers.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'b00,
      MISS_WAIT  = 2'b01,
      REDIR_PEND = 2'b10
   } fetch_state_t;

   localparam int          XLEN_DEFAULT     = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0013;

   // Saturating increment used by the optional event counters.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load captures a fetched instruction, flush
// inserts a bubble, otherwise the contents hold.
module if_id_reg #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            load,
   input  logic            flush,
   input  logic [XLEN-1:0] pc,
   input  logic [31:0]     instr,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_instr,
   output logic [XLEN-1:0] if_id_pc_plus4
);

   logic            valid_reg;
   logic [XLEN-1:0] pc_reg;
   logic [31:0]     instr_reg;
   logic [XLEN-1:0] pc_plus4_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_reg    <= 1'b0;
         pc_reg       <= '0;
         instr_reg    <= '0;
         pc_plus4_reg <= '0;
      end else if (load) begin
         valid_reg    <= 1'b1;
         pc_reg       <= pc;
         instr_reg    <= instr;
         pc_plus4_reg <= pc + XLEN'(4);
      end else if (flush) begin
         // Bubble: only the valid bit drops, payload is left as-is.
         valid_reg    <= 1'b0;
      end
   end

   assign if_id_valid    = valid_reg;
   assign if_id_pc       = pc_reg;
   assign if_id_instr    = instr_reg;
   assign if_id_pc_plus4 = pc_plus4_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, miss/redirect FSM and IF/ID load control.
// Optional event counters are enabled with FETCH_PERF_COUNTERS_EN.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT[XLEN-1:0]
) (
   input  logic            clock,
   input  logic            reset,
   output logic [XLEN-1:0] icache_address,
   input  logic [31:0]     icache_instruction,
   input  logic            icache_busywait,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_target,
`ifdef FETCH_PERF_COUNTERS_EN
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_miss_cycles,
   output logic [31:0]     perf_redirects,
`endif
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_instr,
   output logic [XLEN-1:0] if_id_pc_plus4
);

   fetch_state_t    state_reg, state_next;
   logic [XLEN-1:0] pc_reg, pc_next;
   logic [XLEN-1:0] pend_reg, pend_next;
   logic [XLEN-1:0] aligned_target;
   logic            load, flush;

   assign aligned_target = redirect_target & ~XLEN'(3);
   assign icache_address = pc_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= RUN;
         pc_reg    <= RESET_PC;
         pend_reg  <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         pend_reg  <= pend_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      pend_next  = pend_reg;
      load       = 1'b0;
      flush      = 1'b0;
      case (state_reg)
         REDIR_PEND: begin
            flush = 1'b1;
            if (redirect) begin
               if (icache_busywait) begin
                  pend_next = aligned_target;
               end else begin
                  pc_next    = aligned_target;
                  state_next = RUN;
               end
            end else if (!icache_busywait) begin
               // Fill done: the returned word is wrong-path, drop it.
               pc_next    = pend_reg;
               state_next = RUN;
            end
         end
         default: begin
            // RUN and MISS_WAIT share one rule set; only the state differs.
            if (redirect) begin
               flush = 1'b1;
               if (icache_busywait) begin
                  pend_next  = aligned_target;
                  state_next = REDIR_PEND;
               end else begin
                  pc_next    = aligned_target;
                  state_next = RUN;
               end
            end else if (icache_busywait) begin
               state_next = MISS_WAIT;
               flush      = !stall;
            end else begin
               state_next = RUN;
               if (!stall) begin
                  load    = 1'b1;
                  pc_next = pc_reg + XLEN'(4);
               end
            end
         end
      endcase
   end

   if_id_reg #(.XLEN(XLEN)) u_if_id (
      .clock          (clock),
      .reset          (reset),
      .load           (load),
      .flush          (flush),
      .pc             (pc_reg),
      .instr          (icache_instruction),
      .if_id_valid    (if_id_valid),
      .if_id_pc       (if_id_pc),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus4 (if_id_pc_plus4)
   );

`ifdef FETCH_PERF_COUNTERS_EN
   logic [2:0]  perf_inc;
   logic [31:0] perf_cnt_reg [3];

   assign perf_inc = {redirect, icache_busywait, load};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_perf
         always_ff @(posedge clock) begin
            if (reset)
               perf_cnt_reg[gi] <= '0;
            else if (perf_inc[gi])
               perf_cnt_reg[gi] <= sat_inc(perf_cnt_reg[gi]);
         end
      end
   endgenerate

   assign perf_fetched     = perf_cnt_reg[0];
   assign perf_miss_cycles = perf_cnt_reg[1];
   assign perf_redirects   = perf_cnt_reg[2];
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random
// traffic, all compared against a cycle-level reference model.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] icache_address;
   logic [31:0] icache_instruction;
   logic        icache_busywait = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        if_id_valid;
   logic [31:0] if_id_pc, if_id_instr, if_id_pc_plus4;
`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] perf_fetched, perf_miss_cycles, perf_redirects;
   logic [31:0] m_fetched, m_miss, m_redir;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model state: architectural view, no FSM encoding.
   logic [31:0] m_pc;
   logic        m_pend_v;
   logic [31:0] m_pend;
   logic        m_v;
   logic [31:0] m_ipc, m_instr, m_p4;

   always #5 clock = ~clock;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
   endfunction

   assign icache_instruction = instr_of(icache_address);

   fetch_unit dut (
      .clock              (clock),
      .reset              (reset),
      .icache_address     (icache_address),
      .icache_instruction (icache_instruction),
      .icache_busywait    (icache_busywait),
      .stall              (stall),
      .redirect           (redirect),
      .redirect_target    (redirect_target),
`ifdef FETCH_PERF_COUNTERS_EN
      .perf_fetched       (perf_fetched),
      .perf_miss_cycles   (perf_miss_cycles),
      .perf_redirects     (perf_redirects),
`endif
      .if_id_valid        (if_id_valid),
      .if_id_pc           (if_id_pc),
      .if_id_instr        (if_id_instr),
      .if_id_pc_plus4     (if_id_pc_plus4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_update(input logic rs, input logic bw, input logic st,
                               input logic rd, input logic [31:0] tg);
      logic [31:0] t;
      t = {tg[31:2], 2'b00};
      if (rs) begin
         m_pc = 32'h0; m_pend_v = 1'b0; m_pend = 0;
         m_v = 1'b0; m_ipc = 0; m_instr = 0; m_p4 = 0;
      end else if (rd) begin
         m_v = 1'b0;
         if (bw) begin m_pend_v = 1'b1; m_pend = t; end
         else begin m_pend_v = 1'b0; m_pc = t; end
      end else if (m_pend_v) begin
         m_v = 1'b0;
         if (!bw) begin m_pc = m_pend; m_pend_v = 1'b0; end
      end else if (bw) begin
         if (!st) m_v = 1'b0;
      end else if (!st) begin
         m_v = 1'b1; m_ipc = m_pc; m_instr = instr_of(m_pc); m_p4 = m_pc + 32'd4;
         m_pc = m_pc + 32'd4;
      end
`ifdef FETCH_PERF_COUNTERS_EN
      if (rs) begin m_fetched = 0; m_miss = 0; m_redir = 0; end
      else begin
         if (!rd && !m_pend_v && !bw && !st && m_v && m_ipc + 32'd4 == m_pc) m_fetched++;
         if (bw) m_miss++;
         if (rd) m_redir++;
      end
`endif
   endtask

   // One clock cycle: drive, clock, then compare everything with the model.
   task automatic step(input logic rs, input logic bw, input logic st,
                       input logic rd, input logic [31:0] tg);
      logic was_pend;
      was_pend = m_pend_v;
      reset = rs; icache_busywait = bw; stall = st; redirect = rd; redirect_target = tg;
      @(posedge clock);
      #1;
      model_update(rs, bw, st, rd, tg);
      check("icache_address", icache_address, m_pc);
      check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_v});
      if (m_v) begin
         check("if_id_pc", if_id_pc, m_ipc);
         check("if_id_instr", if_id_instr, m_instr);
         check("if_id_pc_plus4", if_id_pc_plus4, m_p4);
      end
      if (rs) begin
         check("rst_if_id_pc", if_id_pc, 32'h0);
         check("rst_if_id_instr", if_id_instr, 32'h0);
      end
`ifdef FETCH_PERF_COUNTERS_EN
      check("perf_miss", perf_miss_cycles, m_miss);
      check("perf_redir", perf_redirects, m_redir);
      check("perf_fetched", perf_fetched, m_fetched);
`endif
      $display("t=%0t rst=%b bw=%b st=%b rd=%b tgt=%h pend=%b -> addr=%h v=%b pc=%h",
               $time, rs, bw, st, rd, tg, was_pend, icache_address, if_id_valid, if_id_pc);
   endtask

   initial begin
      m_pc = 0; m_pend_v = 0; m_pend = 0; m_v = 0; m_ipc = 0; m_instr = 0; m_p4 = 0;
`ifdef FETCH_PERF_COUNTERS_EN
      m_fetched = 0; m_miss = 0; m_redir = 0;
`endif
      // Reset and straight-line hits.
      step(1, 0, 0, 0, 0);
      check("reset_addr", icache_address, 32'h0);
      check("reset_valid", {31'b0, if_id_valid}, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         step(0, 0, 0, 0, 0);
         check("seq_addr", icache_address, 32'(4 * i));
         check("seq_if_id_pc", if_id_pc, 32'(4 * (i - 1)));
      end

      // Miss at 0x40 lasting five cycles.
      step(0, 0, 0, 1, 32'h40);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 0, 0);
         check("miss_addr_hold", icache_address, 32'h40);
         check("miss_bubble", {31'b0, if_id_valid}, 32'h0);
      end
      step(0, 0, 0, 0, 0);
      check("miss_capture_pc", if_id_pc, 32'h40);
      check("miss_next_addr", icache_address, 32'h44);

      // Redirect on a hit, unaligned target.
      step(0, 0, 0, 1, 32'h103);
      check("redir_addr", icache_address, 32'h100);
      check("redir_bubble", {31'b0, if_id_valid}, 32'h0);
      step(0, 0, 0, 0, 0);
      check("redir_if_id_pc", if_id_pc, 32'h100);

      // Redirect arriving during a miss at 0x80.
      step(0, 0, 0, 1, 32'h80);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 1, 32'h200);
      check("midmiss_hold", icache_address, 32'h80);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("midmiss_target", icache_address, 32'h200);
      check("midmiss_killed", {31'b0, if_id_valid}, 32'h0);

      // Stall hold, then stall together with a redirect.
      step(0, 0, 0, 1, 32'h10);
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 0, 0);
         check("stall_addr", icache_address, 32'h14);
         check("stall_if_id_pc", if_id_pc, 32'h10);
      end
      step(0, 0, 1, 1, 32'h300);
      check("stall_redir", icache_address, 32'h300);

      // Wrap at the top of the address space and reset mid-miss.
      step(0, 0, 0, 1, 32'hFFFF_FFFC);
      step(0, 0, 0, 0, 0);
      check("wrap_addr", icache_address, 32'h0);
      check("wrap_pc_plus4", if_id_pc_plus4, 32'h0);
      step(0, 0, 0, 1, 32'hFFFF_FFFC);
      step(0, 1, 0, 1, 32'h500);
      step(1, 1, 0, 0, 0);
      check("reset_midmiss", icache_address, 32'h0);
      step(0, 0, 0, 0, 0);
      check("reset_drops_pend", icache_address, 32'h4);

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(99) == 0, $urandom_range(9) < 3, $urandom_range(9) < 2,
              $urandom_range(9) == 0, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
